// File: rtl/conv_window_sequencer.sv
// Sliding-window read sequencer for the convolution datapath: walks a KxK window
// over the image buffer and frames the returned taps for the MAC.
`timescale 1ns/1ps
module conv_window_sequencer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conv_start,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int KW    = (K > 1)     ? $clog2(K)     : 1;
  localparam int OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [KW-1:0]     K_LAST    = KW'(K - 1);
  localparam logic [OXW-1:0]    OX_LAST   = OXW'(OUT_W - 1);
  localparam logic [OYW-1:0]    OY_LAST   = OYW'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  // Last window of an output row to first window of the next: +IMG_W-(OUT_W-1) = +K.
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]     kx, ky;
  logic [OXW-1:0]    ox;
  logic [OYW-1:0]    oy;
  logic [ADDR_W-1:0] win_base;  // oy*IMG_W + ox
  logic [ADDR_W-1:0] tap_row;   // ky*IMG_W
  logic              clear, step;
  logic              tap_first, tap_last, win_last;

  assign tap_first = (kx == '0) && (ky == '0);
  assign tap_last  = (kx == K_LAST) && (ky == K_LAST);
  assign win_last  = (ox == OX_LAST) && (oy == OY_LAST);
  assign rd_addr   = win_base + tap_row + ADDR_W'(kx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (conv_start) begin
          state_d = S_HOLD;
          clear   = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        rd_en = 1'b1;
        step  = 1'b1;
        if (tap_last) state_d = win_last ? S_DRAIN : S_HOLD;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address generation is pure stepping: row bases advance by IMG_W, no multiply.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx <= '0; ky <= '0; ox <= '0; oy <= '0;
      win_base <= '0;
      tap_row  <= '0;
    end else if (clear) begin
      kx <= '0; ky <= '0; ox <= '0; oy <= '0;
      win_base <= '0;
      tap_row  <= '0;
    end else if (step) begin
      if (kx != K_LAST) begin
        kx <= kx + 1'b1;
      end else begin
        kx <= '0;
        if (ky != K_LAST) begin
          ky      <= ky + 1'b1;
          tap_row <= tap_row + ROW_STEP;
        end else begin
          ky      <= '0;
          tap_row <= '0;
          if (win_last) begin
            ox <= '0; oy <= '0;
            win_base <= '0;
          end else if (ox != OX_LAST) begin
            ox       <= ox + 1'b1;
            win_base <= win_base + ADDR_W'(1);
          end else begin
            ox       <= '0;
            oy       <= oy + 1'b1;
            win_base <= win_base + WRAP_STEP;
          end
        end
      end
    end
  end

  // Buffer read latency is one cycle, so the framing strobes are the issue flags delayed once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end else begin
      mac_valid <= rd_en;
      mac_first <= rd_en && tap_first;
      mac_last  <= rd_en && tap_last;
    end
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Sequences the convolution datapath once weights and image are loaded into the local buffer and conv_start fires.
- Walks a KxK sliding window (stride 1, no padding) over the IMG_W x IMG_H image held in the image buffer.
- Issues one buffer read per tap and drives MAC framing strobes (valid/first/last) aligned to returned data.
- Throttles window issue on output-side backpressure and reports busy/done to the top-level control FSM.

Parameters:
IMG_W, 28, image width in pixels (>= K)
IMG_H, 28, image height in pixels (>= K)
K, 3, square kernel size (>= 1)
ADDR_W, 10, image buffer address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
conv_start  in  1  start pulse; sampled only in IDLE
out_ready  in  1  downstream can accept one more window result
rd_en  out  1  image buffer read strobe
rd_addr  out  ADDR_W  image buffer read address, row-major
mac_valid  out  1  buffer read data valid this cycle; MAC accumulates
mac_first  out  1  with mac_valid: first tap of a window (clear accumulator)
mac_last  out  1  with mac_valid: last tap of a window (emit result)
busy  out  1  sequencer active
done  out  1  one-cycle pulse: all windows' taps delivered

Behaviour:
- Derived: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1, windows = OUT_W*OUT_H, taps/window = K*K.
- Reset (async assert, sync release): state IDLE; all counters 0; rd_en, rd_addr, mac_valid, mac_first, mac_last, busy, done all 0.
- Counters: kx (fastest), ky, ox, oy (slowest). rd_addr = (oy+ky)*IMG_W + (ox+kx), truncated to ADDR_W. No multiplier on the critical path; keep a row-base register stepping by IMG_W.
- States: IDLE, HOLD, ISSUE, DRAIN, DONE.
- IDLE: conv_start=1 -> HOLD, counters cleared, busy=1 from the next cycle.
- HOLD: window boundary (kx=ky=0). rd_en=0. out_ready=1 -> ISSUE. The tap-0 read is issued in the cycle after out_ready is seen in HOLD.
- ISSUE: rd_en=1 every cycle; one tap per cycle; K*K consecutive cycles per window; no stall mid-window. out_ready is ignored inside a window.
- End of window tap (kx=ky=K-1):
  - More windows remain -> HOLD.
  - Final window -> DRAIN.
- Throughput: with out_ready held at 1, each window costs K*K+1 cycles (one HOLD cycle per window).
- Read latency is fixed at 1 cycle. mac_valid/first/last are rd_en and tap-0 / tap-(K*K-1) flags registered once; mac_first/mac_last are never high without mac_valid.
- DRAIN: one cycle, carries the final mac_last -> DONE.
- DONE: done=1 for exactly one cycle, busy=1 this cycle -> IDLE; busy=0 the following cycle.
- conv_start while busy: ignored, no restart.
- conv_start coincident with done: ignored.
- Reset mid-operation: immediate return to IDLE. In-flight mac_valid is dropped and no done is produced.
- K=1: mac_first and mac_last are high together on every valid.
- Address wrap past IMG_W*IMG_H cannot occur with legal parameters; out-of-range parameter sets are not supported.

Test Plan:
- Params IMG_W=5, IMG_H=4, K=3, out_ready=1, pulse conv_start -> 6 windows, 54 reads. Window 0 addrs 0,1,2,5,6,7,10,11,12. Last window addrs 7,8,9,12,13,14,17,18,19. mac_valid trails rd_en by 1; done pulses once, 2 cycles after the final rd_en; total 60 busy-issue cycles.
- Same params, out_ready=0 for 10 cycles at window 2 boundary -> rd_en=0 throughout, rd_addr of next tap unchanged. Issue resumes with addr 2 (ox=2, oy=0) one cycle after out_ready=1.
- out_ready toggled during a window -> all 9 taps issued back-to-back, no gap, mac_first on tap 0 and mac_last on tap 8 only.
- conv_start re-pulsed mid-run and again in the done cycle -> no address restart, exactly one done; new run starts only on a pulse after busy=0.
- rst low during window 3 tap 4 -> next edge: all outputs 0, IDLE. A new conv_start restarts from addr 0 with correct framing.
- K=1, IMG_W=3, IMG_H=2 -> reads 0..5 in order, mac_first=mac_last=1 on every mac_valid, done after the 6th valid.
